// File: rtl/fetch_hazard_ctrl.sv
// Fetch-stage pipeline sequencer: resolves load-use, branch, trap and multi-cycle
// EX hazards into fetch redirect/stall/NOP controls, and counts stalled cycles.
module fetch_hazard_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int MC_TIMEOUT   = 64,
  parameter int PERF_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [4:0]        ex_rd,
  input  logic              br_taken,
  input  logic [XLEN-1:0]   br_target,
  input  logic              trap_req,
  input  logic [XLEN-1:0]   trap_vec,
  input  logic              mc_start,
  input  logic              mc_done,
  input  logic              perf_clr,
  output logic              stall,
  output logic              issue_nop,
  output logic              jmp,
  output logic [XLEN-1:0]   jmp_pc,
  output logic              ex_bubble,
  output logic              ex_hold,
  output logic              mc_abort,
  output logic              mc_timeout,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_FLUSH   = 2'd1;
  localparam logic [1:0] ST_MC_WAIT = 2'd2;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TCNT_LAST  = 8'(MC_TIMEOUT - 1);

  logic [1:0]        state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [7:0]        tcnt_reg, tcnt_next;
  logic [PERF_W-1:0] perf_reg;

  logic [1:0][4:0] src_idx;
  logic [1:0]      src_use;
  logic [1:0]      src_hit;
  logic            redirect;
  logic            lu_hazard;

  assign src_idx = {id_rs2, id_rs1};
  assign src_use = {id_use_rs2, id_use_rs1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_use[gi] & (src_idx[gi] == ex_rd);
    end
  endgenerate

  // Branches are ignored while EX is frozen on a multi-cycle op; traps never are.
  assign redirect = ~reset & (trap_req | (ex_valid & br_taken & (state_reg != ST_MC_WAIT)));

  assign lu_hazard = ~reset & ~redirect & (state_reg == ST_RUN) & id_valid & ex_valid &
                     ex_is_load & (ex_rd != 5'd0) & (|src_hit);

  assign jmp          = redirect;
  assign jmp_pc       = redirect ? (trap_req ? trap_vec : br_target) : '0;
  assign stall_cycles = reset ? '0 : perf_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    tcnt_next  = tcnt_reg;
    stall      = 1'b0;
    issue_nop  = 1'b0;
    ex_bubble  = 1'b0;
    ex_hold    = 1'b0;
    mc_abort   = 1'b0;
    mc_timeout = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (redirect) begin
          state_next = ST_FLUSH;
          cnt_next   = FLUSH_LOAD;
        end else if (mc_start) begin
          state_next = ST_MC_WAIT;
          tcnt_next  = 8'd0;
        end else if (lu_hazard) begin
          stall     = 1'b1;
          ex_bubble = 1'b1;
        end
      end
      ST_FLUSH: begin
        issue_nop = 1'b1;
        if (redirect) begin
          cnt_next = FLUSH_LOAD;
        end else if (cnt_reg == 4'd0) begin
          state_next = ST_RUN;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ST_MC_WAIT: begin
        if (redirect) begin
          mc_abort   = 1'b1;
          state_next = ST_FLUSH;
          cnt_next   = FLUSH_LOAD;
        end else if (mc_done) begin
          // Completion beats a coincident timeout: EX advances, no pulses.
          state_next = ST_RUN;
        end else begin
          stall   = 1'b1;
          ex_hold = 1'b1;
          if (tcnt_reg == TCNT_LAST) begin
            mc_timeout = 1'b1;
            mc_abort   = 1'b1;
            state_next = ST_RUN;
          end else begin
            tcnt_next = tcnt_reg + 8'd1;
          end
        end
      end
      default: state_next = ST_RUN;
    endcase
    if (reset) begin
      stall      = 1'b0;
      issue_nop  = 1'b0;
      ex_bubble  = 1'b0;
      ex_hold    = 1'b0;
      mc_abort   = 1'b0;
      mc_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_RUN;
      cnt_reg   <= 4'd0;
      tcnt_reg  <= 8'd0;
      perf_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      tcnt_reg  <= tcnt_next;
      if (perf_clr) begin
        perf_reg <= '0;
      end else if (stall && (perf_reg != '1)) begin
        perf_reg <= perf_reg + PERF_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Directed bench: each driven cycle pushes its expected outputs into a queue that a
// negedge monitor pops and compares against the DUT.
module tb_fetch_hazard_ctrl;

  typedef struct packed {
    logic        stall;
    logic        nop;
    logic        jmp;
    logic [31:0] pc;
    logic        bub;
    logic        hold;
    logic        abort;
    logic        tmo;
    logic [15:0] sc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_use_rs1, id_use_rs2;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_valid, ex_is_load, br_taken, trap_req;
  logic [31:0] br_target, trap_vec;
  logic        mc_start, mc_done, perf_clr;
  logic        stall, issue_nop, jmp, ex_bubble, ex_hold, mc_abort, mc_timeout;
  logic [31:0] jmp_pc;
  logic [15:0] stall_cycles;

  exp_t  exp_q[$];
  string tag_q[$];
  exp_t  mon_exp, mon_act;
  string mon_tag;
  int    n_checks = 0;
  int    n_pass   = 0;
  int    exp_sc   = 0;

  fetch_hazard_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .MC_TIMEOUT(64), .PERF_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .br_taken(br_taken), .br_target(br_target),
    .trap_req(trap_req), .trap_vec(trap_vec),
    .mc_start(mc_start), .mc_done(mc_done), .perf_clr(perf_clr),
    .stall(stall), .issue_nop(issue_nop), .jmp(jmp), .jmp_pc(jmp_pc),
    .ex_bubble(ex_bubble), .ex_hold(ex_hold), .mc_abort(mc_abort),
    .mc_timeout(mc_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      mon_act = {stall, issue_nop, jmp, jmp_pc, ex_bubble, ex_hold, mc_abort, mc_timeout, stall_cycles};
      n_checks++;
      if (mon_act === mon_exp) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got stall=%b nop=%b jmp=%b pc=%h bub=%b hold=%b abort=%b tmo=%b sc=%0d; want stall=%b nop=%b jmp=%b pc=%h bub=%b hold=%b abort=%b tmo=%b sc=%0d",
                 mon_tag, mon_act.stall, mon_act.nop, mon_act.jmp, mon_act.pc, mon_act.bub,
                 mon_act.hold, mon_act.abort, mon_act.tmo, mon_act.sc,
                 mon_exp.stall, mon_exp.nop, mon_exp.jmp, mon_exp.pc, mon_exp.bub,
                 mon_exp.hold, mon_exp.abort, mon_exp.tmo, mon_exp.sc);
      end
    end
  end

  task automatic idle();
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
    ex_valid = 0; ex_is_load = 0; ex_rd = 0; br_taken = 0; br_target = 0;
    trap_req = 0; trap_vec = 0; mc_start = 0; mc_done = 0; perf_clr = 0;
  endtask

  // Queue this cycle's expected outputs, then advance one clock.
  task automatic step(input string tag, input logic s, input logic n, input logic j,
                      input logic [31:0] pc, input logic b, input logic h,
                      input logic a, input logic t);
    exp_t e;
    e = '{stall: s, nop: n, jmp: j, pc: pc, bub: b, hold: h, abort: a, tmo: t,
          sc: reset ? 16'd0 : 16'(exp_sc)};
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (reset || perf_clr) exp_sc = 0;
    else if (s) exp_sc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
    id_valid = 1; ex_valid = 1; ex_is_load = 1; ex_rd = rd;
    id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
  endtask

  initial begin
    idle();
    reset = 1;
    @(posedge clk);
    #1;
    step("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    trap_req = 1; trap_vec = 32'h100; ex_valid = 1; br_taken = 1; mc_start = 1;
    set_lu(5'd5, 5'd5, 1, 5'd0, 0);
    step("reset_masks_comb", 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    reset = 0;
    step("idle", 0, 0, 0, 0, 0, 0, 0, 0);

    // Load-use detection
    set_lu(5'd5, 5'd5, 1, 5'd0, 0);
    step("lu_rs1", 1, 0, 0, 0, 1, 0, 0, 0);
    idle();
    step("lu_after", 0, 0, 0, 0, 0, 0, 0, 0);
    set_lu(5'd7, 5'd1, 1, 5'd7, 1);
    step("lu_rs2", 1, 0, 0, 0, 1, 0, 0, 0);
    set_lu(5'd0, 5'd0, 1, 5'd0, 1);
    step("lu_rd0", 0, 0, 0, 0, 0, 0, 0, 0);
    set_lu(5'd9, 5'd9, 0, 5'd3, 1);
    step("lu_unused_src", 0, 0, 0, 0, 0, 0, 0, 0);
    set_lu(5'd9, 5'd9, 1, 5'd0, 0);
    ex_is_load = 0;
    step("lu_not_load", 0, 0, 0, 0, 0, 0, 0, 0);

    // Taken branch and flush window
    idle();
    ex_valid = 1; br_taken = 1; br_target = 32'h40;
    set_lu(5'd5, 5'd5, 1, 5'd0, 0);
    br_taken = 1;
    step("br_jmp", 0, 0, 1, 32'h40, 0, 0, 0, 0);
    idle();
    set_lu(5'd5, 5'd5, 1, 5'd0, 0);
    mc_start = 1;
    step("br_flush1", 0, 1, 0, 0, 0, 0, 0, 0);
    idle();
    step("br_flush2", 0, 1, 0, 0, 0, 0, 0, 0);
    step("br_run", 0, 0, 0, 0, 0, 0, 0, 0);

    // Multi-cycle op finishing after 5 held cycles; branch ignored while held
    mc_start = 1;
    step("mc_start", 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin ex_valid = 1; br_taken = 1; br_target = 32'h80; end
      else begin ex_valid = 0; br_taken = 0; end
      step("mc_wait", 1, 0, 0, 0, 0, 1, 0, 0);
    end
    idle();
    mc_done = 1;
    step("mc_done", 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    step("mc_run", 0, 0, 0, 0, 0, 0, 0, 0);

    // Timeout after 64 held cycles
    mc_start = 1;
    step("to_start", 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    for (int i = 0; i < 63; i++) step("to_wait", 1, 0, 0, 0, 0, 1, 0, 0);
    step("to_pulse", 1, 0, 0, 0, 0, 1, 1, 1);
    step("to_run", 0, 0, 0, 0, 0, 0, 0, 0);

    // Done coinciding with the timeout cycle: no pulses
    mc_start = 1;
    step("dt_start", 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    for (int i = 0; i < 63; i++) step("dt_wait", 1, 0, 0, 0, 0, 1, 0, 0);
    mc_done = 1;
    step("dt_done", 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    step("dt_run", 0, 0, 0, 0, 0, 0, 0, 0);

    // Trap during multi-cycle wait, then a second trap extending the flush
    mc_start = 1;
    step("tr_start", 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    step("tr_wait", 1, 0, 0, 0, 0, 1, 0, 0);
    step("tr_wait", 1, 0, 0, 0, 0, 1, 0, 0);
    trap_req = 1; trap_vec = 32'h100; ex_valid = 1; br_taken = 1; br_target = 32'h40;
    step("trap_mc", 0, 0, 1, 32'h100, 0, 0, 1, 0);
    idle();
    step("tr_flush1", 0, 1, 0, 0, 0, 0, 0, 0);
    trap_req = 1; trap_vec = 32'h200;
    step("trap_in_flush", 0, 1, 1, 32'h200, 0, 0, 0, 0);
    idle();
    step("tr_reload1", 0, 1, 0, 0, 0, 0, 0, 0);
    step("tr_reload2", 0, 1, 0, 0, 0, 0, 0, 0);
    step("tr_run", 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a flush
    ex_valid = 1; br_taken = 1; br_target = 32'h44;
    step("rf_jmp", 0, 0, 1, 32'h44, 0, 0, 0, 0);
    idle();
    step("rf_flush1", 0, 1, 0, 0, 0, 0, 0, 0);
    reset = 1;
    step("rf_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 0;
    step("rf_after", 0, 0, 0, 0, 0, 0, 0, 0);
    set_lu(5'd3, 5'd3, 1, 5'd0, 0);
    step("rf_lu", 1, 0, 0, 0, 1, 0, 0, 0);

    // perf_clr while stalling, then count resumes from zero
    step("pc_stall", 1, 0, 0, 0, 1, 0, 0, 0);
    perf_clr = 1;
    step("pc_clr", 1, 0, 0, 0, 1, 0, 0, 0);
    idle();
    step("pc_zero", 0, 0, 0, 0, 0, 0, 0, 0);

    @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
